// File: rtl/data_memory_hs.sv
// Byte-addressed little-endian data memory with req/ready handshake.
// After reset the whole array is cleared one byte per cycle, then the
// block accepts byte and halfword accesses. A halfword at an odd address
// is either split into two byte cycles or aligned down, depending on
// MISALIGN_SPLIT.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to compare the full address
// against DEPTH. Out-of-range accesses then write nothing, read 0 and pulse
// err. Without the macro the address wraps modulo DEPTH and err stays 0.
module data_memory_hs #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DEPTH          = 64,
  parameter int unsigned MISALIGN_SPLIT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req,
  output logic              ready,
  input  logic              wmem,
  input  logic              memc,
  input  logic              msign,
  input  logic [ADDR_W-1:0] DAddress,
  input  logic [15:0]       DataIn,
  output logic [15:0]       DataOut,
  output logic              rvalid,
  output logic              err
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam bit               SPLIT_EN = (MISALIGN_SPLIT != 0);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SPLIT = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_clr_ptr;
  logic [IDX_W-1:0] r_idx_hi;
  logic [7:0]       r_wdata_hi;
  logic [7:0]       r_lo;
  logic             r_wmem;
  logic             r_oob;
  logic             r_ready;
  logic             r_rvalid;
  logic             r_err;
  logic [15:0]      r_dout;
  logic [7:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_split;
  logic              w_oob;
  logic [ADDR_W-1:0] w_base;
  logic [IDX_W-1:0]  w_idx0;
  logic [IDX_W-1:0]  w_idx1;
  logic [7:0]        w_rd0;
  logic [7:0]        w_rd1;
  logic [7:0]        w_rd_hi;
  logic              w_we0;
  logic              w_we1;
  logic [IDX_W-1:0]  w_wa0;
  logic [IDX_W-1:0]  w_wa1;
  logic [7:0]        w_wd0;
  logic [7:0]        w_wd1;

  // Request decode: first affected byte address and its neighbour
  assign w_accept = req & r_ready;
  assign w_split  = memc & DAddress[0] & SPLIT_EN;
  assign w_base   = (memc && !w_split) ? {DAddress[ADDR_W-1:1], 1'b0} : DAddress;
  assign w_idx0   = w_base[IDX_W-1:0];
  assign w_idx1   = w_idx0 + IDX_W'(1);
  assign w_rd0    = r_mem[w_idx0];
  assign w_rd1    = r_mem[w_idx1];
  assign w_rd_hi  = r_mem[r_idx_hi];

`ifdef DMEM_BOUNDS_CHECK_EN
  logic [ADDR_W:0] w_last;

  // Last affected byte on the unwrapped address decides range
  assign w_last = {1'b0, w_base} + (ADDR_W+1)'(memc);
  assign w_oob  = (w_last >= (ADDR_W+1)'(DEPTH));
`else
  logic w_unused_hi;

  assign w_unused_hi = |w_base[ADDR_W-1:IDX_W];
  assign w_oob       = 1'b0;
`endif

  // Memory write port selection: clear, accepted access, or split second byte
  always_comb begin
    w_we0 = 1'b0;
    w_we1 = 1'b0;
    w_wa0 = w_idx0;
    w_wa1 = w_idx1;
    w_wd0 = DataIn[7:0];
    w_wd1 = DataIn[15:8];
    case (r_state)
      ST_CLEAR: begin
        w_we0 = 1'b1;
        w_wa0 = r_clr_ptr;
        w_wd0 = 8'h00;
      end
      ST_IDLE: begin
        if (w_accept && wmem && !w_oob) begin
          w_we0 = 1'b1;
          w_we1 = memc & ~w_split;
        end
      end
      ST_SPLIT: begin
        w_we0 = r_wmem & ~r_oob;
        w_wa0 = r_idx_hi;
        w_wd0 = r_wdata_hi;
      end
      default: begin
        w_we0 = 1'b0;
      end
    endcase
  end

  // Storage array; contents are only ever initialised by the clear sweep
  always_ff @(posedge CLK) begin
    if (w_we0) r_mem[w_wa0] <= w_wd0;
    if (w_we1) r_mem[w_wa1] <= w_wd1;
  end

  // Control FSM with registered handshake and read outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_idx_hi   <= '0;
      r_wdata_hi <= 8'h00;
      r_lo       <= 8'h00;
      r_wmem     <= 1'b0;
      r_oob      <= 1'b0;
      r_ready    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_dout     <= 16'h0000;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + IDX_W'(1);
          if (r_clr_ptr == LAST_IDX) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            if (w_split) begin
              r_state    <= ST_SPLIT;
              r_ready    <= 1'b0;
              r_idx_hi   <= w_idx1;
              r_wdata_hi <= DataIn[15:8];
              r_lo       <= w_rd0;
              r_wmem     <= wmem;
              r_oob      <= w_oob;
            end else begin
              r_err <= w_oob;
              if (!wmem) begin
                r_rvalid <= 1'b1;
                if (w_oob)     r_dout <= 16'h0000;
                else if (memc) r_dout <= {w_rd1, w_rd0};
                else           r_dout <= {{8{msign & w_rd0[7]}}, w_rd0};
              end
            end
          end
        end
        ST_SPLIT: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_err   <= r_oob;
          if (!r_wmem) begin
            r_rvalid <= 1'b1;
            r_dout   <= r_oob ? 16'h0000 : {w_rd_hi, r_lo};
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign DataOut = r_dout;
  assign rvalid  = r_rvalid;
  assign err     = r_err;

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: directed scenarios and random traffic checked
// against a byte-array reference model of the memory.
module tb_data_memory_hs;

  localparam int unsigned DEPTH = 64;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_ON = 1'b1;
`else
  localparam bit BOUNDS_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req;
  logic        ready;
  logic        wmem;
  logic        memc;
  logic        msign;
  logic [15:0] DAddress;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        rvalid;
  logic        err;

  int n_vec;
  int n_err;

  logic [7:0]  mem_m [DEPTH];
  logic [15:0] last_dout;

  data_memory_hs #(
    .ADDR_W(16),
    .DEPTH(DEPTH),
    .MISALIGN_SPLIT(1)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .req(req),
    .ready(ready),
    .wmem(wmem),
    .memc(memc),
    .msign(msign),
    .DAddress(DAddress),
    .DataIn(DataIn),
    .DataOut(DataOut),
    .rvalid(rvalid),
    .err(err)
  );

  always #5 CLK = ~CLK;

  function automatic void model_clear();
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 8'h00;
    last_dout = 16'h0000;
  endfunction

  // Expected {DataOut, rvalid latency, err latency, ready-low cycles}
  function automatic logic [24:0] model_txn(input logic w, input logic m, input logic s,
                                            input logic [15:0] addr, input logic [15:0] data);
    int a;
    int n;
    bit split;
    bit oob;
    int lat;
    int elat;
    logic [7:0] b0;
    logic [7:0] b1;
    split = m && addr[0];
    a     = (m && !split) ? int'(addr & 16'hFFFE) : int'(addr);
    n     = m ? 2 : 1;
    oob   = BOUNDS_ON && ((a + n - 1) >= int'(DEPTH));
    b0    = mem_m[a % DEPTH];
    b1    = mem_m[(a + 1) % DEPTH];
    if (w) begin
      if (!oob) begin
        mem_m[a % DEPTH] = data[7:0];
        if (m) mem_m[(a + 1) % DEPTH] = data[15:8];
      end
    end else if (oob) last_dout = 16'h0000;
    else if (m)       last_dout = {b1, b0};
    else              last_dout = {{8{s & b0[7]}}, b0};
    lat  = w ? 0 : (split ? 2 : 1);
    elat = oob ? (split ? 2 : 1) : 0;
    return {last_dout, 3'(lat), 3'(elat), 3'(split ? 1 : 0)};
  endfunction

  // Drive one access and observe the response window; also returns model expectation
  task automatic run_txn(input logic w, input logic m, input logic s,
                         input logic [15:0] addr, input logic [15:0] data,
                         output logic [24:0] obs, output logic [24:0] expv);
    int waitc;
    int lat;
    int elat;
    int rlow;
    logic [15:0] d;
    @(negedge CLK);
    waitc = 0;
    while (!ready && waitc < 200) begin
      @(negedge CLK);
      waitc++;
    end
    req = 1'b1; wmem = w; memc = m; msign = s; DAddress = addr; DataIn = data;
    @(posedge CLK);
    #1;
    req = 1'b0; DataIn = 16'($urandom); DAddress = 16'($urandom);
    lat = 0; elat = 0; rlow = 0; d = 16'h0000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      if (rvalid && lat == 0) begin
        lat = k;
        d   = DataOut;
      end
      if (err && elat == 0) elat = k;
      if (!ready) rlow++;
    end
    if (lat == 0) d = DataOut;
    obs  = (waitc >= 200) ? '1 : {d, 3'(lat), 3'(elat), 3'(rlow)};
    expv = model_txn(w, m, s, addr, data);
  endtask

  task automatic release_and_count(output int cnt);
    @(negedge CLK);
    RESET = 1'b1;
    cnt = 0;
    while (!ready && cnt < 200) begin
      @(negedge CLK);
      cnt++;
    end
    model_clear();
  endtask

  task automatic test_reset();
    int cnt;
    logic [24:0] o;
    logic [24:0] e;
    logic [34:0] t[$];
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_vec++;
      if ({ready, rvalid, err, DataOut} !== 19'h0) begin
        n_err++;
        $display("FAIL reset_outputs: got %h expected 0", {ready, rvalid, err, DataOut});
      end
    end
    release_and_count(cnt);
    n_vec++;
    if (cnt !== 64) begin
      n_err++;
      $display("FAIL clear_cycles: got %0d expected 64", cnt);
    end
    t = '{ {1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000},
           {1'b0, 1'b1, 1'b0, 16'h003E, 16'h0000} };
    foreach (t[i]) begin
      run_txn(t[i][34], t[i][33], t[i][32], t[i][31:16], t[i][15:0], o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_read[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_aligned();
    logic [24:0] o;
    logic [24:0] e;
    logic [34:0] t[$];
    t = '{ {1'b1, 1'b1, 1'b0, 16'h0004, 16'h1234},
           {1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000},
           {1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000},
           {1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000} };
    foreach (t[i]) begin
      run_txn(t[i][34], t[i][33], t[i][32], t[i][31:16], t[i][15:0], o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL aligned[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_split();
    logic [24:0] o;
    logic [24:0] e;
    logic [34:0] t[$];
    t = '{ {1'b1, 1'b1, 1'b0, 16'h0007, 16'hBEEF},
           {1'b0, 1'b0, 1'b0, 16'h0007, 16'h0000},
           {1'b0, 1'b0, 1'b0, 16'h0008, 16'h0000},
           {1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000} };
    foreach (t[i]) begin
      run_txn(t[i][34], t[i][33], t[i][32], t[i][31:16], t[i][15:0], o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL split[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_byte_sign();
    logic [24:0] o;
    logic [24:0] e;
    logic [34:0] t[$];
    t = '{ {1'b1, 1'b0, 1'b0, 16'h0010, 16'h5580},
           {1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000},
           {1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000},
           {1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000} };
    foreach (t[i]) begin
      run_txn(t[i][34], t[i][33], t[i][32], t[i][31:16], t[i][15:0], o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL byte_sign[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [24:0] o;
    logic [24:0] e;
    logic [34:0] t[$];
    t = '{ {1'b1, 1'b1, 1'b0, 16'h003F, 16'hA55A},
           {1'b0, 1'b0, 1'b0, 16'h003F, 16'h0000},
           {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000},
           {1'b0, 1'b1, 1'b0, 16'h003F, 16'h0000},
           {1'b1, 1'b1, 1'b0, 16'h0040, 16'h1111},
           {1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000},
           {1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000} };
    foreach (t[i]) begin
      run_txn(t[i][34], t[i][33], t[i][32], t[i][31:16], t[i][15:0], o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] e;
    logic [15:0] a;
    logic [7:0]  d;
    int waitc;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom_range(0, 63));
      d = 8'($urandom);
      @(negedge CLK);
      waitc = 0;
      while (!ready && waitc < 200) begin
        @(negedge CLK);
        waitc++;
      end
      req = 1'b1; wmem = 1'b1; memc = 1'b0; msign = 1'b0; DAddress = a; DataIn = {8'h00, d};
      @(negedge CLK);
      wmem = 1'b0; msign = i[0];
      @(posedge CLK);
      #1;
      req = 1'b0;
      @(negedge CLK);
      e = model_txn(1'b1, 1'b0, 1'b0, a, {8'h00, d});
      e = model_txn(1'b0, 1'b0, i[0], a, 16'h0000);
      n_vec++;
      if ({rvalid, DataOut} !== {1'b1, e[24:9]}) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, {rvalid, DataOut}, {1'b1, e[24:9]});
      end
    end
  endtask

  task automatic test_random();
    logic [24:0] o;
    logic [24:0] e;
    logic w;
    logic m;
    logic s;
    logic [15:0] a;
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
      run_txn(w, m, s, a, 16'($urandom), o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL random[%0d] w=%b m=%b s=%b a=%h: got %h expected %h", i, w, m, s, a, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int cnt;
    int waitc;
    logic [24:0] o;
    logic [24:0] e;
    logic [34:0] t[$];
    // Reset while a read result is being presented
    @(negedge CLK);
    waitc = 0;
    while (!ready && waitc < 200) begin
      @(negedge CLK);
      waitc++;
    end
    req = 1'b1; wmem = 1'b0; memc = 1'b1; msign = 1'b0; DAddress = 16'h0004;
    @(posedge CLK);
    #1;
    req = 1'b0;
    n_vec++;
    if ({ready, rvalid} !== 2'b11) begin
      n_err++;
      $display("FAIL pre_reset_rvalid: got %b expected 11", {ready, rvalid});
    end
    RESET = 1'b0;
    #1;
    n_vec++;
    if ({ready, rvalid, err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_drop_read: got %b expected 000", {ready, rvalid, err});
    end
    release_and_count(cnt);
    n_vec++;
    if (cnt !== 64) begin
      n_err++;
      $display("FAIL reclear_cycles_a: got %0d expected 64", cnt);
    end
    // Reset in the middle of a split write
    run_txn(1'b1, 1'b1, 1'b0, 16'h0004, 16'hC3A7, o, e);
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL prefill: got %h expected %h", o, e);
    end
    @(negedge CLK);
    req = 1'b1; wmem = 1'b1; memc = 1'b1; DAddress = 16'h0011; DataIn = 16'h9876;
    @(posedge CLK);
    #1;
    req = 1'b0;
    n_vec++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL split_ready_low: got %b expected 0", ready);
    end
    RESET = 1'b0;
    #1;
    n_vec++;
    if ({ready, rvalid, err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_drop_split: got %b expected 000", {ready, rvalid, err});
    end
    release_and_count(cnt);
    n_vec++;
    if (cnt !== 64) begin
      n_err++;
      $display("FAIL reclear_cycles_b: got %0d expected 64", cnt);
    end
    t = '{ {1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000},
           {1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000},
           {1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000},
           {1'b0, 1'b0, 1'b0, 16'h0012, 16'h0000},
           {1'b0, 1'b1, 1'b0, 16'h003E, 16'h0000} };
    foreach (t[i]) begin
      run_txn(t[i][34], t[i][33], t[i][32], t[i][31:16], t[i][15:0], o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL after_reclear[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RESET = 1'b0;
    req = 1'b0; wmem = 1'b0; memc = 1'b0; msign = 1'b0;
    DAddress = 16'h0000; DataIn = 16'h0000;
    model_clear();
    test_reset();
    test_aligned();
    test_split();
    test_byte_sign();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
